// File: rtl/demux1_2_if.sv
// demux1_2_if: AXI4-Stream beat bundle (tdata/tvalid/tlast/tready).
// master drives the beat and samples tready; slave does the reverse.
interface demux1_2_if #(
  parameter int unsigned width = 8
);
  logic [width-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/demux1_2.sv
// demux1_2: frame-aware AXI4-Stream 1-to-2 demultiplexer.
// sel is sampled on the first beat of a frame and held until its tlast beat
// is accepted. A registered output stage gives one cycle of latency.
// Define DEMUX1_2_SKID_EN to add a one-beat skid buffer, which makes
// s_axis.tready a registered signal.
module demux1_2 #(
  parameter int unsigned width = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  demux1_2_if.slave   s_axis,
  demux1_2_if.master  m0_axis,
  demux1_2_if.master  m1_axis
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             route_q, route_d;
  logic             rdy_en_q;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             out_dest_q, out_dest_d;
  logic             in_dest, in_xfer, out_xfer, s_ready;

  // Destination of the beat currently on the input
  always_comb in_dest = (state_q == IDLE) ? sel : route_q;

  // Handshake qualifiers for the input and the shared output register
  always_comb begin
    out_xfer = out_valid_q & (out_dest_q ? m1_axis.tready : m0_axis.tready);
    in_xfer  = s_axis.tvalid & s_ready;
  end

  // Route FSM: lock the destination for the remainder of a multi-beat frame
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (in_xfer) begin
      if (state_q == IDLE) begin
        if (!s_axis.tlast) begin
          state_d = BUSY;
          route_d = sel;
        end
      end else if (s_axis.tlast) begin
        state_d = IDLE;
      end
    end
  end

  // Startup gate, FSM and route registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      state_q  <= IDLE;
      route_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      state_q  <= state_d;
      route_q  <= route_d;
    end
  end

`ifdef DEMUX1_2_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [width-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;
  logic             skid_dest_q, skid_dest_d;
  logic             out_free;

  // Input is accepted whenever the skid slot is empty; no m->s comb path
  always_comb s_ready = rdy_en_q & ~skid_valid_q;

  // Output register refills from the skid first so beat order is preserved;
  // an input beat arriving while the output is stalled parks in the skid.
  always_comb begin
    out_free     = ~out_valid_q | out_xfer;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    out_dest_d   = out_dest_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_dest_d  = skid_dest_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_dest_d   = skid_dest_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_data_d  = s_axis.tdata;
        out_last_d  = s_axis.tlast;
        out_dest_d  = in_dest;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_data_d  = s_axis.tdata;
      skid_last_d  = s_axis.tlast;
      skid_dest_d  = in_dest;
      skid_valid_d = 1'b1;
    end
  end

  // Skid buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_dest_q  <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_dest_q  <= skid_dest_d;
    end
  end
`else
  // Accept when the output register is empty or draining this cycle
  always_comb s_ready = rdy_en_q & (~out_valid_q | out_xfer);

  // Output register loads on input accept, otherwise empties on transfer
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    out_dest_d  = out_dest_q;
    if (in_xfer) begin
      out_data_d  = s_axis.tdata;
      out_last_d  = s_axis.tlast;
      out_dest_d  = in_dest;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Shared output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dest_q  <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      out_dest_q  <= out_dest_d;
    end
  end

  assign s_axis.tready  = s_ready;
  assign m0_axis.tdata  = out_data_q;
  assign m0_axis.tlast  = out_last_q;
  assign m0_axis.tvalid = out_valid_q & ~out_dest_q;
  assign m1_axis.tdata  = out_data_q;
  assign m1_axis.tlast  = out_last_q;
  assign m1_axis.tvalid = out_valid_q & out_dest_q;

endmodule
